// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / IO) arbiter for block RAM port A; returns registered read data with a valid pulse.
// Optional build macro ARB_CPU_PRIORITY_EN: fixed CPU priority with a 15-loss IO starvation escape.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int READ_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_read_lat
        $error("mem_port_arbiter: READ_LAT must be in 1..7");
    end

    localparam logic [2:0] RL3     = 3'(READ_LAT);
    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_IO  = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    // Owner of the access in flight; doubles as last_owner for the next tie.
    logic          owner_q, owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] io_rdata_q, io_rdata_d;
    logic          pick_io;
`ifdef ARB_CPU_PRIORITY_EN
    logic [3:0]    starve_q, starve_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        pick_io     = 1'b0;
        cpu_gnt     = 1'b0;
        io_gnt      = 1'b0;
        cpu_rvalid  = 1'b0;
        io_rvalid   = 1'b0;
        mem_wren    = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
        starve_d    = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
`ifdef ARB_CPU_PRIORITY_EN
                    // IO only breaks a tie once it has lost fifteen in a row.
                    pick_io = io_req && (!cpu_req || starve_q == 4'hF);
                    if (pick_io) begin
                        starve_d = 4'h0;
                    end else if (io_req) begin
                        starve_d = starve_q + 4'h1;
                    end
`else
                    pick_io = io_req && (!cpu_req || owner_q == OWN_CPU);
`endif
                    owner_d     = pick_io;
                    we_d        = pick_io ? io_we    : cpu_we;
                    mem_addr_d  = pick_io ? io_addr  : cpu_addr;
                    mem_wdata_d = pick_io ? io_wdata : cpu_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cpu_gnt  = (owner_q == OWN_CPU);
                io_gnt   = (owner_q == OWN_IO);
                mem_wren = we_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = RL3;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'h1;
                // Last wait cycle: memory output is valid now.
                if (cnt_q == 3'h1) begin
                    if (owner_q == OWN_IO) begin
                        io_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                cpu_rvalid = (owner_q == OWN_CPU);
                io_rvalid  = (owner_q == OWN_IO);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'h0;
            we_q        <= 1'b0;
            owner_q     <= OWN_IO;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
`ifdef ARB_CPU_PRIORITY_EN
            starve_q    <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
`ifdef ARB_CPU_PRIORITY_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model plus directed and randomized traffic.
module tb_mem_port_arbiter;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [15:0] io_addr = '0, io_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_wren, busy;
    logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mem_port_arbiter #(.AW(16), .DW(16), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int a);
        if (a == 16'h0010) return 16'hBEEF;
        if (a == 16'h0030) return 16'hC0DE;
        if (a == 16'h0031) return 16'h10AD;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // Block RAM with RL-cycle registered read path.
    logic [15:0] ram [0:65535];
    logic [15:0] pipe [0:RL-1];
    initial for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RL-1];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // Reference model: an access sampled in IDLE cycle s occupies cycles s+1..s+k_end-1;
    // k counts cycles since the sample.
    logic [15:0] shadow [0:65535];
    bit          armed = 0, m_act = 0, m_io = 0, m_we = 0, m_last_io = 1;
    int          m_k = 0, m_starve = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_cpu_rd = '0, m_io_rd = '0;
    bit          ecg, eig, ecr, eir, ewr, pick;

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (armed) begin
                ecg = 0; eig = 0; ecr = 0; eir = 0; ewr = 0;
                if (m_act && m_k == 1) begin
                    if (m_io) eig = 1; else ecg = 1;
                    ewr = m_we;
                end
                if (m_act && !m_we && m_k == RL + 2) begin
                    if (m_io) eir = 1; else ecr = 1;
                end
                chk("cpu_gnt", 32'(cpu_gnt), 32'(ecg));
                chk("io_gnt", 32'(io_gnt), 32'(eig));
                chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecr));
                chk("io_rvalid", 32'(io_rvalid), 32'(eir));
                chk("mem_wren", 32'(mem_wren), 32'(ewr));
                chk("busy", 32'(busy), 32'(m_act));
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
                chk("io_rdata", 32'(io_rdata), 32'(m_io_rd));
            end
            if (m_act && m_k == 1 && m_we) shadow[m_addr] = m_wdata;
            if (m_act && !m_we && m_k == RL + 1) begin
                if (m_io) m_io_rd = shadow[m_addr]; else m_cpu_rd = shadow[m_addr];
            end
            if (reset) begin
                armed = 1; m_act = 0; m_addr = '0; m_wdata = '0;
                m_cpu_rd = '0; m_io_rd = '0; m_last_io = 1; m_starve = 0;
            end else if (m_act) begin
                m_k++;
                if (m_k == (m_we ? 2 : RL + 3)) m_act = 0;
            end else if (cpu_req || io_req) begin
`ifdef ARB_CPU_PRIORITY_EN
                pick = io_req && (!cpu_req || m_starve == 15);
                if (pick) m_starve = 0; else if (io_req) m_starve++;
`else
                pick = io_req && (!cpu_req || !m_last_io);
`endif
                m_act = 1; m_k = 1; m_io = pick; m_last_io = pick;
                m_we    = pick ? io_we    : cpu_we;
                m_addr  = pick ? io_addr  : cpu_addr;
                m_wdata = pick ? io_wdata : cpu_wdata;
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return cpu_gnt;
            1: return io_gnt;
            2: return cpu_rvalid;
            default: return io_rvalid;
        endcase
    endfunction

    task automatic wait_flag(input string nm, input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; failures++;
            $display("FAIL timeout_%s: no pulse within %0d cycles", nm, budget);
        end
    endtask

    int c0, g, r, n, cnt;
    int ord [4];
    int exp_ord [4];
    bit cg, ig;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_wren", 32'(mem_wren), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_io_rdata", 32'(io_rdata), 0);

        // CPU read of 0x0010
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; c0 = cyc;
        wait_flag("t1_gnt", 0, 20, g);
        chk("t1_gnt_cycle", g, c0 + 1);
        @(posedge clk); #1 cpu_req = 0;
        wait_flag("t1_rvalid", 2, 20, r);
        chk("t1_rvalid_cycle", r, g + 3);
        chk("t1_rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("t1_busy_at_rvalid", 32'(busy), 1);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 0);

        // IO write 0x0200 <= 0x1234
        @(posedge clk); #1;
        io_req = 1; io_we = 1; io_addr = 16'h0200; io_wdata = 16'h1234; c0 = cyc;
        wait_flag("t2_gnt", 1, 20, g);
        chk("t2_gnt_cycle", g, c0 + 1);
        chk("t2_wren", 32'(mem_wren), 1);
        chk("t2_addr", 32'(mem_addr), 32'h0200);
        chk("t2_wdata", 32'(mem_wdata), 32'h1234);
        @(posedge clk); #1 io_req = 0; io_we = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(mem_wren) + int'(io_rvalid) + int'(cpu_rvalid);
        end
        chk("t2_no_extra_wren_rvalid", cnt, 0);

        // Both requesters hold reads: grant order
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
        io_req = 1; io_we = 0; io_addr = 16'h0031;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (cpu_gnt && io_gnt) chk("t3_dual_gnt", 1, 0);
            if (cpu_gnt) begin ord[n] = 0; n++; end
            else if (io_gnt) begin ord[n] = 1; n++; end
        end
        @(posedge clk); #1 cpu_req = 0; io_req = 0;
        chk("t3_grant_count", n, 4);
`ifdef ARB_CPU_PRIORITY_EN
        exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0; exp_ord[3] = 0;
        wait_flag("t3_last_rvalid", 2, 20, r);
`else
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
        wait_flag("t3_last_rvalid", 3, 20, r);
        chk("t3_io_rdata", 32'(io_rdata), 32'h10AD);
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), ord[i], exp_ord[i]);
        chk("t3_cpu_rdata", 32'(cpu_rdata), 32'hC0DE);

        // Reset during WAIT of a CPU read
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        wait_flag("t4_gnt", 0, 20, g);
        @(posedge clk); #1 cpu_req = 0; reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t4_busy_after_reset", 32'(busy), 0);
        chk("t4_cpu_rdata_cleared", 32'(cpu_rdata), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cnt += int'(cpu_rvalid);
            @(negedge clk);
        end
        chk("t4_no_cpu_rvalid", cnt, 0);
        @(posedge clk); #1;
        io_req = 1; io_we = 0; io_addr = 16'h0200; c0 = cyc;
        wait_flag("t4_io_gnt", 1, 20, g);
        chk("t4_io_gnt_cycle", g, c0 + 1);
        @(posedge clk); #1 io_req = 0;
        wait_flag("t4_io_rvalid", 3, 20, r);
        chk("t4_io_rdata", 32'(io_rdata), 32'h1234);

        // CPU drops req right after the IDLE sample
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0031; c0 = cyc;
        @(posedge clk); #1 cpu_req = 0;
        wait_flag("t5_gnt", 0, 5, g);
        chk("t5_gnt_cycle", g, c0 + 1);
        wait_flag("t5_rvalid", 2, 10, r);
        chk("t5_rvalid_cycle", r, c0 + 4);
        chk("t5_rdata", 32'(cpu_rdata), 32'h10AD);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cg = cpu_gnt; ig = io_gnt;
            @(posedge clk); #1;
            if (reset) reset = 0;
            else if ($urandom_range(0, 299) == 0) reset = 1;
            if (cg || !cpu_req) begin
                cpu_req = ($urandom_range(0, 9) < 6);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 16'h0100 + 16'($urandom_range(0, 7));
                cpu_wdata = 16'($urandom);
            end else if ($urandom_range(0, 49) == 0) cpu_req = 0;
            if (ig || !io_req) begin
                io_req = ($urandom_range(0, 9) < 6);
                io_we = 1'($urandom_range(0, 1));
                io_addr = 16'h0100 + 16'($urandom_range(0, 7));
                io_wdata = 16'($urandom);
            end else if ($urandom_range(0, 49) == 0) io_req = 0;
        end
        cpu_req = 0; io_req = 0; reset = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
